scsi_io_arbiter: RTL and testbench
==================================

Name: scsi_io_arbiter

Overview:
- Sits directly downstream of the ncr5380 block.
- Consumes the per-target sector requests (io_lba/io_rd/io_wr per device) and serialises them onto the single block-I/O channel of the IO controller.
- Routes io_ack, the buffer write strobe and buffer read data back to the granted target only.
- Uses round-robin arbitration among DEVS targets, with one transfer in flight at a time.

Parameters:
- DEVS, 2: number of SCSI targets; must match the ncr5380 DEVS.
- DEVW, $clog2(DEVS) (minimum 1): width of the device index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dev_lba  in  32 x DEVS (unpacked)  per-target sector LBA
- dev_rd  in  DEVS  per-target read request, level, held until its dev_ack is seen
- dev_wr  in  DEVS  per-target write request, level, held until its dev_ack is seen
- dev_ack  out  DEVS  per-target acknowledge
- dev_buff_din  in  8 x DEVS (unpacked)  per-target buffer read data (data going to the SD card)
- dev_buff_wr  out  1  buffer write strobe toward the targets, gated to transfer phase
- sd_lba  out  32  LBA to the IO controller
- sd_rd  out  1  read request to the IO controller
- sd_wr  out  1  write request to the IO controller
- sd_ack  in  1  IO controller acknowledge; high for the whole transfer
- sd_buff_wr  in  1  IO controller buffer write strobe
- sd_buff_din  out  8  buffer read data, muxed from the granted target
- sd_dev  out  DEVW  index of the granted target
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset state: IDLE, grant=0, rr_ptr=0. sd_lba=0, sd_rd=0, sd_wr=0, dev_ack=0, busy=0, sd_dev=0.
- Reset mid-transfer behaves the same way: outputs drop on the next edge and any in-flight request is abandoned.

State machine: IDLE -> REQ -> XFER -> GAP -> IDLE.
- IDLE:
  - Grants only when sd_ack==0 and some (dev_rd|dev_wr) bit is set.
  - Winner = first requesting index searched upward from rr_ptr, wrapping mod DEVS.
  - On that edge: grant<=winner; sd_lba<=dev_lba[winner]; sd_rd<=dev_rd[winner]; sd_wr<=dev_wr[winner] & ~dev_rd[winner] (read wins if both are set); state<=REQ.
  - Latency from request to sd_rd/sd_wr high is 1 clock.
  - If sd_ack is still high (e.g. after reset mid-transfer), IDLE holds until sd_ack falls.
- REQ:
  - sd_rd/sd_wr stay high and sd_lba stays stable.
  - On the first edge where sd_ack==1: sd_rd<=0, sd_wr<=0, state<=XFER.
  - No timeout.
  - Changes to dev_lba or dev_rd after the grant are ignored, since the values are latched.
- XFER:
  - On the first edge where sd_ack==0: state<=GAP, rr_ptr<=(grant==DEVS-1)?0:grant+1.
- GAP:
  - Exactly one cycle, then IDLE.
  - Guarantees the granted target has sampled its ack and dropped its request before re-arbitration.

Outputs:
- dev_ack[i] = sd_ack & (state==REQ|state==XFER) & (grant==i). Combinational, so no added latency. All other bits are 0.
- dev_buff_wr = sd_buff_wr & (state==XFER | state==REQ). The ncr5380 already gates this per target_bsy.
- sd_buff_din = dev_buff_din[grant], mux registered-select / combinational-data, so it is valid in the same cycle as sd_buff_addr.
- sd_dev = grant.
- sd_lba holds its last value after a transfer until the next grant.

Boundary conditions:
- Simultaneous requests from all targets: served one per transaction in rr order starting at rr_ptr.
- A single target requesting repeatedly still gets one GAP between its transfers.
- A new request arriving during REQ/XFER/GAP waits, with no loss, because requests are level-held.
- sd_ack going high while in IDLE (spurious): ignored and no grant; dev_ack stays 0.
- DEVS==1: rr_ptr stays 0 and DEVW=1.

Test Plan:
- Single read: dev_rd=2'b01, dev_lba[0]=32'h0000_1234.
  - Next edge: sd_rd=1, sd_lba=32'h1234, sd_dev=0.
  - Raise sd_ack for 512 cycles -> sd_rd drops on the next edge and dev_ack=2'b01 while sd_ack is high.
  - After sd_ack falls: GAP for 1 cycle, then IDLE, busy=0.
- Contention: dev_rd=2'b11 from reset.
  - Device 0 is granted first.
  - After its transfer completes, device 1 is granted with sd_lba=dev_lba[1]; dev_ack[0] is never high during the device 1 transfer.
- Write with buffer routing: dev_wr[1]=1, dev_buff_din[1]=8'hA5, dev_buff_din[0]=8'h3C -> sd_wr=1, sd_rd=0, sd_buff_din=8'hA5.
- Write with strobe gating: sd_buff_wr pulses in XFER -> dev_buff_wr pulses; the same pulse in IDLE -> dev_buff_wr=0.
- Read priority: dev_rd[0]=1 and dev_wr[0]=1 -> sd_rd=1, sd_wr=0.
- Reset mid-transfer: reset asserted in XFER while sd_ack=1.
  - Next edge: all outputs 0, rr_ptr=0.
  - With a pending dev_rd=2'b10, no grant while sd_ack stays high; sd_ack falls -> device 1 is granted 1 cycle later.

Source files
------------

// File: rtl/scsi_io_arbiter.sv
// rtl/scsi_io_arbiter.sv - round-robin arbiter serialising per-target sector requests onto one block-I/O channel
//
// Purpose:
//   Collects level-held read/write sector requests from DEVS SCSI targets and
//   presents them one at a time to the IO controller. The granted target alone
//   sees the acknowledge, the buffer write strobe and has its buffer read data
//   forwarded to the controller.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   dev_lba[DEVS]     per-target sector LBA
//   dev_rd, dev_wr    per-target read/write request (level, held until dev_ack)
//   dev_ack           per-target acknowledge (only the granted bit can be high)
//   dev_buff_din[]    per-target buffer read data toward the IO controller
//   dev_buff_wr       buffer write strobe toward the targets
//   sd_lba/sd_rd/sd_wr  request to the IO controller
//   sd_ack            IO controller acknowledge, high for the whole transfer
//   sd_buff_wr        IO controller buffer write strobe
//   sd_buff_din       buffer read data of the granted target
//   sd_dev            index of the granted target
//   busy              arbiter is not idle
module scsi_io_arbiter #(
    parameter int DEVS = 2,
    parameter int DEVW = (DEVS > 1) ? $clog2(DEVS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     dev_lba [DEVS],
    input  logic [DEVS-1:0] dev_rd,
    input  logic [DEVS-1:0] dev_wr,
    output logic [DEVS-1:0] dev_ack,
    input  logic [7:0]      dev_buff_din [DEVS],
    output logic            dev_buff_wr,
    output logic [31:0]     sd_lba,
    output logic            sd_rd,
    output logic            sd_wr,
    input  logic            sd_ack,
    input  logic            sd_buff_wr,
    output logic [7:0]      sd_buff_din,
    output logic [DEVW-1:0] sd_dev,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_GAP
    } state_t;

    localparam logic [DEVW:0]   DEVS_W   = DEVS[DEVW:0];
    localparam logic [DEVW-1:0] LAST_DEV = DEVW'(DEVS - 1);

    state_t          state_q, state_d;
    logic [DEVW-1:0] grant_q, grant_d;
    logic [DEVW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     sd_lba_q, sd_lba_d;
    logic            sd_rd_q, sd_rd_d;
    logic            sd_wr_q, sd_wr_d;

    logic [DEVS-1:0] req;
    logic            found;
    logic [DEVW-1:0] winner;
    logic [DEVW:0]   sum;
    logic [DEVW-1:0] idx;
    logic            active;

    assign req = dev_rd | dev_wr;

    // Round-robin search: walk offsets from the farthest back to rr_ptr so the
    // last hit, i.e. the nearest requester at or above rr_ptr, wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = DEVS - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (DEVW + 1)'(k);
            if (sum >= DEVS_W) begin
                sum = sum - DEVS_W;
            end
            idx = sum[DEVW-1:0];
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = sd_rd_q;
        sd_wr_d  = sd_wr_q;
        case (state_q)
            ST_IDLE: begin
                // A still-high sd_ack (left over from an abandoned transfer)
                // blocks new grants until the controller releases it.
                if (!sd_ack && found) begin
                    grant_d  = winner;
                    sd_lba_d = dev_lba[winner];
                    sd_rd_d  = dev_rd[winner];
                    sd_wr_d  = dev_wr[winner] & ~dev_rd[winner];
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!sd_ack) begin
                    rr_ptr_d = (grant_q == LAST_DEV) ? '0 : grant_q + DEVW'(1);
                    state_d  = ST_GAP;
                end
            end
            default: begin
                // One idle cycle lets the target see its ack drop and release
                // its request before the next arbitration.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            sd_lba_q <= '0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            sd_lba_q <= sd_lba_d;
            sd_rd_q  <= sd_rd_d;
            sd_wr_q  <= sd_wr_d;
        end
    end

    assign active = (state_q == ST_REQ) || (state_q == ST_XFER);

    genvar gi;
    generate
        for (gi = 0; gi < DEVS; gi++) begin : g_ack
            assign dev_ack[gi] = sd_ack & active & (grant_q == DEVW'(gi));
        end
    endgenerate

    assign dev_buff_wr = sd_buff_wr & active;
    assign sd_buff_din = dev_buff_din[grant_q];
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign sd_dev      = grant_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// tb/tb_scsi_io_arbiter.sv - randomized self-checking bench for scsi_io_arbiter
module tb_scsi_io_arbiter;

    localparam int DEVS = 2;
    localparam int DEVW = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     dev_lba [DEVS];
    logic [DEVS-1:0] dev_rd;
    logic [DEVS-1:0] dev_wr;
    logic [DEVS-1:0] dev_ack;
    logic [7:0]      dev_buff_din [DEVS];
    logic            dev_buff_wr;
    logic [31:0]     sd_lba;
    logic            sd_rd;
    logic            sd_wr;
    logic            sd_ack;
    logic            sd_buff_wr;
    logic [7:0]      sd_buff_din;
    logic [DEVW-1:0] sd_dev;
    logic            busy;

    always #5 clk = ~clk;

    scsi_io_arbiter #(.DEVS(DEVS)) dut (
        .clk          (clk),
        .reset        (reset),
        .dev_lba      (dev_lba),
        .dev_rd       (dev_rd),
        .dev_wr       (dev_wr),
        .dev_ack      (dev_ack),
        .dev_buff_din (dev_buff_din),
        .dev_buff_wr  (dev_buff_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .sd_dev       (sd_dev),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding requests per target and the rotating start.
    bit          pend_rd [DEVS];
    bit          pend_wr [DEVS];
    logic [31:0] lba_m   [DEVS];
    int          ptr_m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < DEVS; i++) begin
            dev_rd[i]  = pend_rd[i];
            dev_wr[i]  = pend_wr[i];
            dev_lba[i] = lba_m[i];
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < DEVS; k++) begin
            int i;
            i = (ptr_m + k) % DEVS;
            if (pend_rd[i] || pend_wr[i]) return i;
        end
        return -1;
    endfunction

    task automatic add_random_reqs();
        for (int i = 0; i < DEVS; i++) begin
            if (!pend_rd[i] && !pend_wr[i] && $urandom_range(0, 1) == 1) begin
                int kind;
                kind       = $urandom_range(0, 2);
                pend_rd[i] = (kind != 1);
                pend_wr[i] = (kind != 0);
                lba_m[i]   = $urandom;
            end
        end
    endtask

    // Runs one complete transaction starting in IDLE with at least one request
    // pending, acting as IO controller and targets; ends back in IDLE.
    task automatic run_txn(input int xfer_len, input bit spurious, input bit add_new);
        int          w;
        logic [31:0] exp_lba;
        logic        exp_rd;
        logic        exp_wr;
        drive_reqs();
        if (spurious) begin
            sd_ack = 1'b1;
            repeat (2) begin
                tick();
                chk("spur_busy", busy, 0);
                chk("spur_sd_rd", sd_rd, 0);
                chk("spur_dev_ack", dev_ack, 0);
            end
            sd_ack = 1'b0;
        end
        w       = pick();
        exp_lba = lba_m[w];
        exp_rd  = pend_rd[w];
        exp_wr  = pend_wr[w] & ~pend_rd[w];
        tick();
        chk("grant_sd_dev", sd_dev, w);
        chk("grant_sd_rd", sd_rd, exp_rd);
        chk("grant_sd_wr", sd_wr, exp_wr);
        chk("grant_sd_lba", sd_lba, exp_lba);
        chk("grant_busy", busy, 1);
        chk("grant_dev_ack", dev_ack, 0);
        if (add_new) add_random_reqs();
        drive_reqs();
        dev_lba[w] = ~lba_m[w];
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk("req_hold_rd", sd_rd, exp_rd);
            chk("req_hold_lba", sd_lba, exp_lba);
        end
        sd_ack     = 1'b1;
        sd_buff_wr = 1'($urandom_range(0, 1));
        #1;
        chk("req_dev_ack", dev_ack, 32'(1) << w);
        chk("req_buff_wr", dev_buff_wr, sd_buff_wr);
        tick();
        chk("xfer_sd_rd", sd_rd, 0);
        chk("xfer_sd_wr", sd_wr, 0);
        chk("xfer_busy", busy, 1);
        for (int j = 0; j < xfer_len; j++) begin
            sd_buff_wr = 1'($urandom_range(0, 1));
            for (int i = 0; i < DEVS; i++) dev_buff_din[i] = 8'($urandom);
            #1;
            chk("xfer_buff_wr", dev_buff_wr, sd_buff_wr);
            chk("xfer_buff_din", sd_buff_din, dev_buff_din[w]);
            chk("xfer_dev_ack", dev_ack, 32'(1) << w);
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        pend_rd[w] = 1'b0;
        pend_wr[w] = 1'b0;
        ptr_m      = (w + 1) % DEVS;
        if (add_new) add_random_reqs();
        drive_reqs();
        #1;
        chk("ackfall_dev_ack", dev_ack, 0);
        tick();
        chk("gap_busy", busy, 1);
        chk("gap_sd_rd", sd_rd, 0);
        chk("gap_lba_hold", sd_lba, exp_lba);
        sd_buff_wr = 1'b1;
        #1;
        chk("gap_buff_wr", dev_buff_wr, 0);
        sd_buff_wr = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_lba_hold", sd_lba, exp_lba);
        sd_buff_wr = 1'b1;
        #1;
        chk("idle_buff_wr", dev_buff_wr, 0);
        sd_buff_wr = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        ptr_m      = 0;
        for (int i = 0; i < DEVS; i++) begin
            pend_rd[i]      = 1'b0;
            pend_wr[i]      = 1'b0;
            lba_m[i]        = '0;
            dev_buff_din[i] = '0;
        end
        drive_reqs();
        repeat (2) tick();
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sd_dev", sd_dev, 0);
        chk("rst_dev_ack", dev_ack, 0);
        reset = 1'b0;

        // Contention from reset: device 0 first, then device 1.
        pend_rd[0] = 1'b1; lba_m[0] = 32'h0000_0100;
        pend_rd[1] = 1'b1; lba_m[1] = 32'h0000_0200;
        run_txn(4, 1'b0, 1'b0);
        run_txn(4, 1'b0, 1'b0);

        // Single long read.
        pend_rd[0] = 1'b1; lba_m[0] = 32'h0000_1234;
        run_txn(512, 1'b0, 1'b0);

        // Write on device 1, then read priority on device 0.
        pend_wr[1] = 1'b1; lba_m[1] = 32'h0000_0BEE;
        run_txn(6, 1'b0, 1'b0);
        pend_rd[0] = 1'b1; pend_wr[0] = 1'b1; lba_m[0] = 32'h0000_0777;
        run_txn(3, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            while (pick() < 0) add_random_reqs();
            run_txn($urandom_range(1, 6), 1'($urandom_range(0, 3) == 0), 1'b1);
        end
        while (pick() >= 0) run_txn(2, 1'b0, 1'b0);

        // Move the pointer to 1, then abandon a device-1 transfer by reset.
        pend_rd[0] = 1'b1; lba_m[0] = 32'h0000_0AAA;
        run_txn(2, 1'b0, 1'b0);
        pend_rd[1] = 1'b1; lba_m[1] = 32'h0000_0BBB;
        drive_reqs();
        tick();
        chk("prerst_sd_dev", sd_dev, 1);
        sd_ack = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr_m = 0;
        chk("midrst_sd_rd", sd_rd, 0);
        chk("midrst_sd_lba", sd_lba, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sd_dev", sd_dev, 0);
        chk("midrst_dev_ack", dev_ack, 0);
        pend_rd[0] = 1'b1; lba_m[0] = 32'h0000_0CCC;
        drive_reqs();
        repeat (2) begin
            tick();
            chk("ackhigh_busy", busy, 0);
            chk("ackhigh_sd_rd", sd_rd, 0);
        end
        sd_ack = 1'b0;
        tick();
        chk("postrst_sd_dev", sd_dev, pick());
        chk("postrst_sd_rd", sd_rd, 1);
        chk("postrst_sd_lba", sd_lba, 32'h0000_0CCC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
